branch_ctrl: RTL
================

Name: branch_ctrl

Overview:
- Program-counter sequencer and the consumer of the PSR flag register. Evaluates 4-bit condition codes against the stored FLCNZ flags for Bcond, Jcond and Scond instructions.
- Owns the PC and drives the instruction-memory fetch handshake.
- Sits between the instruction decoder, the PSR `flag_out` and instruction memory.

Parameters:
- RESET_VEC, 16'h0000, PC value loaded on reset.
- PC_STEP, 2, sequential PC increment in bytes; instructions are 16-bit.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- flag_in  in  5  PSR flags: [4]F [3]L [2]C [1]N [0]Z.
- psr_busy  in  1  a flag-writing ALU op is in flight; flags are not yet valid.
- imem_req  out  1  fetch request.
- imem_addr  out  16  fetch address; equals pc.
- imem_ack  in  1  fetch complete; instruction is available to the decoder.
- dec_valid  in  1  decoder result is valid this cycle.
- dec_op  in  3  0 NONE, 1 BCOND, 2 JCOND, 3 SCOND, 4 HALT; 5-7 are treated as NONE.
- dec_cond  in  4  condition code.
- dec_disp  in  16  two's-complement PC-relative displacement (BCOND).
- dec_target  in  16  absolute target from the register file (JCOND).
- pc  out  16  current PC.
- br_taken  out  1  one-cycle pulse on a redirect; used as the pipeline flush.
- scond_we  out  1  one-cycle register write-enable for Scond.
- scond_data  out  16  {15'b0, cond_true}.
- misalign  out  1  one-cycle pulse when a computed target is odd.
- halted  out  1  high while in HALT.

Behaviour:
- Reset, asynchronous and taking effect immediately:
  - pc = RESET_VEC; state = FETCH.
  - imem_req, br_taken, scond_we, misalign and halted are 0; scond_data = 0.
  - Reset mid-fetch drops imem_req without waiting for imem_ack.
  - The first request asserts in the first cycle after RESET deasserts.
- Condition table (cond_true), evaluated combinationally from flag_in:
  - 0 EQ Z=1; 1 NE Z=0; 2 CS C=1; 3 CC C=0.
  - 4 HI L=1; 5 LS L=0; 6 GT N=1; 7 LE N=0.
  - 8 FS F=1; 9 FC F=0.
  - A LO Z=0&L=0; B HS Z=1|L=1; C LT Z=0&N=0; D GE Z=1|N=1.
  - E UC always 1; F never 0.
- State FETCH:
  - imem_req=1 and imem_addr=pc, both held stable until imem_ack.
  - On imem_ack, go to DECODE; imem_req is 0 the following cycle.
- State DECODE:
  - Wait for dec_valid.
  - If dec_valid and psr_busy, and dec_op is BCOND, JCOND or SCOND: stall in DECODE with no outputs. Evaluate in the first cycle with dec_valid=1 and psr_busy=0. The decoder holds its outputs during the stall.
  - NONE: pc += PC_STEP; go to FETCH.
  - BCOND: if taken, pc = pc + dec_disp modulo 2^16 and br_taken=1; else pc += PC_STEP. Go to FETCH.
  - JCOND: if taken, pc = dec_target and br_taken=1; else pc += PC_STEP. Go to FETCH.
  - SCOND: scond_we=1 and scond_data={15'b0, cond_true}; pc += PC_STEP; go to FETCH.
  - HALT: go to HALT; pc is unchanged.
- State HALT: halted=1; all inputs are ignored; only RESET exits.
- PC arithmetic:
  - All PC arithmetic is 16-bit unsigned with wrap-around. 16'hFFFE + 2 = 16'h0000, and displacements that overflow wrap.
  - Odd taken target: load pc with bit0 cleared and pulse misalign with br_taken in the same cycle.
- Pulse and handshake rules:
  - br_taken, scond_we and misalign are registered. Each is high for exactly the one cycle after the evaluating edge, aligned with the new pc.
  - imem_ack outside FETCH is ignored.
  - dec_valid outside DECODE is ignored.
- Flags are never modified by this block.

Decomposition:
- Shared package (`cpu_pkg`):
  - Flag bit indices F_BIT=4, L_BIT=3, C_BIT=2, N_BIT=1, Z_BIT=0.
  - Condition-code constants EQ..UC and NEVER.
  - dec_op encodings.
  - State encoding FETCH, DECODE, HALT.
- Sub-module `cond_eval`: combinational, flags[4:0] and cond[3:0] in, cond_true out. It is reused by any later conditional-move logic.

Test Plan:
- Reset and sequential fetch:
  - Stimulus: RESET pulse, then NONE ops with imem_ack one cycle after each request.
  - Required: imem_addr 0000, 0002, 0004; no pulses.
- BEQ taken and not taken:
  - Stimulus: pc=0010, flag_in=00001, BCOND cond=0, disp=FFF0.
  - Required: pc=0000 and br_taken=1 for one cycle.
  - Repeat with flag_in=00000. Required: pc=0012 and br_taken=0.
- Full condition sweep:
  - Stimulus: all 16 conds × all 32 flag values via JCOND with target 0100.
  - Required: taken exactly per the condition table; cond F never taken; cond E always taken.
- Scond and psr_busy stall:
  - Stimulus: SCOND cond=2 with psr_busy=1 for 3 cycles, then flag_in C=1 with psr_busy=0.
  - Required: no scond_we during the stall, then scond_we=1 with scond_data=0001 and pc+2.
- Wrap and misalign:
  - Stimulus: pc=FFFE with NONE. Required: next fetch at 0000.
  - Stimulus: JCOND UC with target 0101. Required: pc=0100 and misalign=1 together with br_taken.
- Reset mid-fetch and HALT:
  - Stimulus: RESET asserted while imem_req=1 before ack. Required: imem_req falls immediately and pc=RESET_VEC.
  - Stimulus: HALT op. Required: halted=1, no further imem_req until RESET.

Source files
------------

// File: rtl/cpu_pkg.sv
// ============================================================================
// cpu_pkg : flag bit indices, condition codes, decoder ops and sequencer states
// Revision: 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int F_BIT = 4;
    localparam int L_BIT = 3;
    localparam int C_BIT = 2;
    localparam int N_BIT = 1;
    localparam int Z_BIT = 0;

    localparam logic [3:0] COND_EQ    = 4'h0;
    localparam logic [3:0] COND_NE    = 4'h1;
    localparam logic [3:0] COND_CS    = 4'h2;
    localparam logic [3:0] COND_CC    = 4'h3;
    localparam logic [3:0] COND_HI    = 4'h4;
    localparam logic [3:0] COND_LS    = 4'h5;
    localparam logic [3:0] COND_GT    = 4'h6;
    localparam logic [3:0] COND_LE    = 4'h7;
    localparam logic [3:0] COND_FS    = 4'h8;
    localparam logic [3:0] COND_FC    = 4'h9;
    localparam logic [3:0] COND_LO    = 4'hA;
    localparam logic [3:0] COND_HS    = 4'hB;
    localparam logic [3:0] COND_LT    = 4'hC;
    localparam logic [3:0] COND_GE    = 4'hD;
    localparam logic [3:0] COND_UC    = 4'hE;
    localparam logic [3:0] COND_NEVER = 4'hF;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_BCOND = 3'd1;
    localparam logic [2:0] OP_JCOND = 3'd2;
    localparam logic [2:0] OP_SCOND = 3'd3;
    localparam logic [2:0] OP_HALT  = 3'd4;

    localparam logic [1:0] ST_FETCH  = 2'd0;
    localparam logic [1:0] ST_DECODE = 2'd1;
    localparam logic [1:0] ST_HALT   = 2'd2;

endpackage

`default_nettype wire

// File: rtl/cond_eval.sv
// ============================================================================
// cond_eval : combinational 4-bit condition code test against FLCNZ flags
// Revision: 1.0
// ============================================================================
`default_nettype none

module cond_eval
    import cpu_pkg::*;
(
    input  logic [4:0] flags,
    input  logic [3:0] cond,
    output logic       cond_true
);

    logic w_f, w_l, w_c, w_n, w_z;

    assign w_f = flags[F_BIT];
    assign w_l = flags[L_BIT];
    assign w_c = flags[C_BIT];
    assign w_n = flags[N_BIT];
    assign w_z = flags[Z_BIT];

    always_comb begin
        cond_true = 1'b0;
        case (cond)
            COND_EQ:    cond_true = w_z;
            COND_NE:    cond_true = ~w_z;
            COND_CS:    cond_true = w_c;
            COND_CC:    cond_true = ~w_c;
            COND_HI:    cond_true = w_l;
            COND_LS:    cond_true = ~w_l;
            COND_GT:    cond_true = w_n;
            COND_LE:    cond_true = ~w_n;
            COND_FS:    cond_true = w_f;
            COND_FC:    cond_true = ~w_f;
            COND_LO:    cond_true = ~w_z & ~w_l;
            COND_HS:    cond_true = w_z | w_l;
            COND_LT:    cond_true = ~w_z & ~w_n;
            COND_GE:    cond_true = w_z | w_n;
            COND_UC:    cond_true = 1'b1;
            COND_NEVER: cond_true = 1'b0;
            default:    cond_true = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/branch_ctrl.sv
// ============================================================================
// branch_ctrl : PC sequencer with fetch handshake and conditional redirects
// Revision: 1.0
// ============================================================================
`default_nettype none

module branch_ctrl
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_VEC = 16'h0000,
    parameter logic [15:0] PC_STEP   = 16'd2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [4:0]  flag_in,
    input  logic        psr_busy,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic        dec_valid,
    input  logic [2:0]  dec_op,
    input  logic [3:0]  dec_cond,
    input  logic [15:0] dec_disp,
    input  logic [15:0] dec_target,
    output logic [15:0] pc,
    output logic        br_taken,
    output logic        scond_we,
    output logic [15:0] scond_data,
    output logic        misalign,
    output logic        halted
);

    logic [1:0]  state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic        req_q, req_d;
    logic        br_q, br_d;
    logic        we_q, we_d;
    logic        mis_q, mis_d;
    logic        sbit_q, sbit_d;

    logic [2:0]  w_op;
    logic        w_stall;
    logic        w_cond_true;
    logic [15:0] w_target;

    cond_eval u_cond_eval (
        .flags     (flag_in),
        .cond      (dec_cond),
        .cond_true (w_cond_true)
    );

    assign w_op     = (dec_op > OP_HALT) ? OP_NONE : dec_op;
    // Only flag consumers wait on an in-flight ALU op; NONE and HALT proceed.
    assign w_stall  = psr_busy && ((w_op == OP_BCOND) || (w_op == OP_JCOND) || (w_op == OP_SCOND));
    assign w_target = (w_op == OP_JCOND) ? dec_target : (pc_q + dec_disp);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        br_d    = 1'b0;
        we_d    = 1'b0;
        mis_d   = 1'b0;
        sbit_d  = sbit_q;
        case (state_q)
            ST_FETCH: begin
                if (imem_ack) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (dec_valid && !w_stall) begin
                    state_d = ST_FETCH;
                    pc_d    = pc_q + PC_STEP;
                    case (w_op)
                        OP_BCOND, OP_JCOND: begin
                            if (w_cond_true) begin
                                pc_d  = {w_target[15:1], 1'b0};
                                br_d  = 1'b1;
                                mis_d = w_target[0];
                            end
                        end
                        OP_SCOND: begin
                            we_d   = 1'b1;
                            sbit_d = w_cond_true;
                        end
                        OP_HALT: begin
                            state_d = ST_HALT;
                            pc_d    = pc_q;
                        end
                        default: ;
                    endcase
                end
            end
            ST_HALT: ;
            default: state_d = ST_FETCH;
        endcase
        // Request tracks the next state so it drops the cycle after an ack.
        req_d = (state_d == ST_FETCH);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_VEC;
            req_q   <= 1'b0;
            br_q    <= 1'b0;
            we_q    <= 1'b0;
            mis_q   <= 1'b0;
            sbit_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            br_q    <= br_d;
            we_q    <= we_d;
            mis_q   <= mis_d;
            sbit_q  <= sbit_d;
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign br_taken   = br_q;
    assign scond_we   = we_q;
    assign scond_data = {15'b0, sbit_q};
    assign misalign   = mis_q;
    assign halted     = (state_q == ST_HALT);

endmodule

`default_nettype wire
